rv32m_muldiv_unit: RTL and testbench
====================================

// Module: rv32m_muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide execution unit for the pipelined RV32 core.
//   It sits beside the ALU in EX and accepts one M-extension op at a time.
//   While an op runs, busy holds the pipeline (stall IF/ID/EX, bubble into MEM).
//   The result is presented with a one-cycle done pulse for capture into the EX->MEM pipe register.
// PARAMETERS
//   XLEN      32   operand/result width; must be even and >= 8
//   CNT_W     $clog2(XLEN)+1   iteration counter width (derived, do not override)
// PORTS
//   clk      in   1     core clock, rising edge
//   rst      in   1     synchronous, active-high reset
//   start    in   1     launch op; accepted only when busy==0 and flush==0
//   op       in   3     RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   src_a    in   XLEN  rs1 value (already forwarded), sampled on accepted start
//   src_b    in   XLEN  rs2 value (already forwarded), sampled on accepted start
//   flush    in   1     abort in-flight op (branch taken / exception)
//   busy     out  1     op in flight (CALC or DONE state); drives core stall
//   done     out  1     one-cycle pulse; result valid this cycle
//   result   out  XLEN  op result; holds its value until the next done
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result=0, counter=0.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: accepted start latches op, |a|, |b|, sign flags; next state CALC (or DONE for special cases below).
//   - CALC: one iteration per cycle, XLEN cycles (counter XLEN-1 down to 0), then DONE.
//   - DONE: done=1, result valid; next state IDLE. A new start is accepted in the cycle after DONE.
//   Latency: start at cycle 0 -> done at cycle XLEN+1 (33 for XLEN=32). Special cases -> done at cycle 1.
//   busy=1 from cycle 1 through the done cycle inclusive. start while busy is ignored, with no side effect.
//   Multiply: shift-add over magnitudes into a 2*XLEN product. Negate when the operand signs differ.
//     Signed operands: MULH both; MULHSU src_a only; MUL/MULHU none.
//     MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
//   Divide: restoring, 1 quotient bit/cycle, on magnitudes.
//     Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
//   Special cases, resolved in IDLE without CALC:
//     - divisor==0: DIV/DIVU -> all ones; REM/REMU -> src_a.
//     - signed overflow (a=most-negative, b=-1): DIV -> most-negative; REM -> 0.
//   flush: in any state, next state IDLE; done is not asserted and result is unchanged.
//     flush with start in the same cycle: flush wins and start is dropped.
//     flush in the DONE cycle: done is still 1 that cycle (already committed); the core discards it.
//   rst mid-operation: immediate return to the reset values on the next edge.
//   Arithmetic is modulo 2^XLEN on outputs; internal partial remainder is XLEN+1 bits.
// CONFIGURATION
//   RV32M_FAST_MUL_EN defined: all multiply ops use a single-cycle combinational XLEN x XLEN
//     signed-extended product. IDLE->DONE directly, done at cycle 1. Divide is unchanged.
//   Not defined: multiply uses the iterative path above (XLEN+1 cycle latency).
//     No hardware multiplier is inferred.
// TESTING
//   MUL a=7,b=-3 -> result=0xFFFFFFEB; done at cycle 33 (cycle 1 with RV32M_FAST_MUL_EN); busy high cycles 1..33.
//   MULH a=0x80000000,b=0x80000000 -> 0x40000000. MULHSU a=-1,b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same -> 0xFFFFFFFE.
//   DIV a=-7,b=2 -> -3 (0xFFFFFFFD); REM -> -1. DIVU a=0xFFFFFFFF,b=16 -> 0x0FFFFFFF; REMU -> 0xF.
//   Special cases, done at cycle 1:
//     - DIV a=5,b=0 -> 0xFFFFFFFF; REMU a=5,b=0 -> 5.
//     - DIV a=0x80000000,b=-1 -> 0x80000000; REM -> 0.
//   DIVU started, flush at cycle 10 -> busy=0 at cycle 11, done never pulses, result keeps previous value.
//     New DIVU start at cycle 11 completes normally at cycle 44.
//   Second start during busy is ignored (result from the first op only).
//   rst at cycle 5 of a MUL -> busy=0, done=0, result=0 next cycle.
//   Back-to-back start directly after done produces the correct second result.

Source files
------------

// File: rtl/rv32m_muldiv_unit.sv
// rtl/rv32m_muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Optional single-cycle multiply when RV32M_FAST_MUL_EN is defined.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   prod_q;
  logic                neg_q, neg_r;

  logic                is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, special, fast;
  logic [XLEN-1:0]     special_res, fast_res;
  logic                accept;

  assign accept = start && !flush && (state_q == S_IDLE);

  // Operand decode on the raw (unlatched) inputs for the accepting cycle
  always_comb begin
    is_div   = op[2];
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (is_div && !op[0]);
    b_signed = (op == OP_MULH) || (is_div && !op[0]);
    a_neg    = a_signed && src_a[XLEN-1];
    b_neg    = b_signed && src_b[XLEN-1];
    a_mag    = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag    = b_neg ? (~src_b + 1'b1) : src_b;
    div_zero = is_div && (src_b == '0);
    div_ovf  = is_div && !op[0] && (src_a == MOST_NEG) && (src_b == '1);
    special_res = '0;
    if (div_zero)     special_res = op[1] ? src_a : '1;
    else if (div_ovf) special_res = op[1] ? '0 : MOST_NEG;
    special  = div_zero || div_ovf;
  end

`ifdef RV32M_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;
  always_comb begin
    fast_a    = $signed({a_signed && src_a[XLEN-1], src_a});
    fast_b    = $signed({b_signed && src_b[XLEN-1], src_b});
    fast_prod = fast_a * fast_b;
    fast      = !is_div;
    fast_res  = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  // One iteration: multiply keeps {acc_hi, multiplier}; divide keeps {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] step_next, mul_p;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (!op_q[2])
      step_next = {mul_sum, prod_q[XLEN-1:1]};
    else if (!div_trial[XLEN])
      step_next = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    else
      step_next = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};

    mul_p = neg_q ? (~step_next + 1'b1) : step_next;
    quo   = step_next[XLEN-1:0];
    rem   = step_next[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      final_res = mul_p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_p[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = neg_q ? (~quo + 1'b1) : quo;
      default:                     final_res = neg_r ? (~rem + 1'b1) : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (special || fast) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op;
        cnt_q  <= CNT_W'(XLEN - 1);
        opnd_q <= is_div ? b_mag : a_mag;
        prod_q <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        if (special)   result <= special_res;
        else if (fast) result <= fast_res;
      end else if (state_q == S_CALC && !flush) begin
        prod_q <= step_next;
        cnt_q  <= cnt_q - 1'b1;
        if (cnt_q == '0) result <= final_res;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb/tb_rv32m_muldiv_unit.sv - self-checking bench for rv32m_muldiv_unit
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  rv32m_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef RV32M_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int lat, output logic [31:0] res);
    int cyc;
    logic busy_bad;
    cyc = cyc0;
    busy_bad = 1'b0;
    while (!done && cyc < 200) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!busy) busy_bad = 1'b1;
    lat = cyc;
    res = result;
    check("busy_during_op", {31'b0, busy_bad}, 32'd0);
    @(posedge clk); #1;
    check("idle_after_done", {30'b0, busy, done}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat;
    logic [31:0] res;
    launch(o, a, b);
    wait_done(1, lat, res);
    check({name, "_result"}, res, exp);
    check({name, "_latency"}, lat, exp_lat(o, a, b));
  endtask

  initial begin
    int lat;
    logic [31:0] res, ra, rb;
    logic [2:0]  ro;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF};
    vecs[7]  = '{3'd7, 32'hFFFF_FFFF,  32'd16,        32'h0000_000F};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, 30'b0} | result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d", i), ro, ra, rb, ref_model(ro, ra, rb));
    end

    // Start while busy must be ignored
    launch(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'd5; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, lat, res);
    check("ignored_start_result", res, 32'hFFFF_FFEB);
    check("ignored_start_latency", lat, exp_lat(3'd0, 32'd7, 32'hFFFF_FFFD));

    // Reset mid-operation
    launch(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_op", {busy, done, 30'b0} | result, 32'd0);
    rst = 1'b0;

    // Flush mid-divide, then a fresh divide right after
    run_op("pre_flush", 3'd5, 32'd100, 32'd7, 32'd14);
    launch(3'd5, 32'hFFFF_FFFF, 32'd16);
    for (int c = 1; c < 10; c++) begin
      check("no_done_before_flush", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_done", {30'b0, busy, done}, 32'd0);
    check("flush_result_kept", result, 32'd14);
    run_op("after_flush", 3'd5, 32'd1000, 32'd10, 32'd100);

    // Flush and start together: start dropped
    start = 1'b1; flush = 1'b1; op = 3'd4; src_a = 32'd5; src_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", {30'b0, busy, done}, 32'd0);
    @(posedge clk); #1;
    check("flush_start_result_kept", result, 32'd100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
